alu_exec_unit: RTL and testbench

//  Parametrised RV32I/M execute unit: decodes alu_op/funct3/funct7 and computes the result.

---
 rtl/alu_exec_if.sv | 35 +++
 rtl/alu_exec_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alu_exec_if                                                     |
// | Purpose : Request/response bundle between control unit and alu_exec_unit  |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            op_5;
    logic            funct7_5;
    logic            funct7_0;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_op, funct3, op_5, funct7_5, funct7_0, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct3, op_5, funct7_5, funct7_0, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alu_exec_unit                                                   |
// | Purpose : RV32I/M execute unit, iterative multiplier, optional divider    |
// |           (divider built only when ALU_EXEC_DIV_EN is defined)            |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic      clk,
    input  logic      reset,
    alu_exec_if.slave bus
);

    localparam int                 c_SHAMT_W    = $clog2(XLEN);
    localparam int                 c_CNT_W      = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_CYCLES = c_CNT_W'(XLEN / MUL_STEP);
    localparam logic [c_CNT_W-1:0] c_DIV_CYCLES = c_CNT_W'(XLEN);
    localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [XLEN-1:0]     r_result;
    logic                r_zero;
    logic                r_illegal;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_is_m;
    logic                w_is_mul;
    logic                w_is_div;
    logic [c_SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]     w_base_res;

    logic                w_a_sgn;
    logic                w_b_sgn;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;

    logic                w_load;
    logic [XLEN-1:0]     w_load_val;
    logic                w_load_ill;
    logic                w_mul_start;
    logic                w_div_start;

    logic [2*XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_mplier;
    logic                r_mul_neg;
    logic                r_mul_hi;
    logic [2*XLEN-1:0]   w_mul_add;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_mul_res;

    // DONE holds the result; a drain in DONE may overlap the next accept.
    assign w_in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign w_accept      = bus.in_valid && w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;

    assign w_is_m   = (bus.alu_op == 2'b10) && bus.op_5 && bus.funct7_0;
    assign w_is_mul = w_is_m && !bus.funct3[2];
    assign w_is_div = w_is_m &&  bus.funct3[2];
    assign w_shamt  = bus.src_b[c_SHAMT_W-1:0];

    always_comb begin
        w_base_res = '0;
        case (bus.alu_op)
            2'b00: w_base_res = bus.src_a + bus.src_b;
            2'b01: w_base_res = bus.src_a - bus.src_b;
            2'b11: w_base_res = bus.src_b;
            default: begin
                case (bus.funct3)
                    3'b000:  w_base_res = (bus.op_5 && bus.funct7_5) ? (bus.src_a - bus.src_b)
                                                                     : (bus.src_a + bus.src_b);
                    3'b001:  w_base_res = bus.src_a << w_shamt;
                    3'b010:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
                    3'b011:  w_base_res = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
                    3'b100:  w_base_res = bus.src_a ^ bus.src_b;
                    3'b101:  w_base_res = bus.funct7_5 ? $unsigned($signed(bus.src_a) >>> w_shamt)
                                                       : (bus.src_a >> w_shamt);
                    3'b110:  w_base_res = bus.src_a | bus.src_b;
                    default: w_base_res = bus.src_a & bus.src_b;
                endcase
            end
        endcase
    end

    // Operand signedness: mulh/mulhsu sign A, mulh signs B; div/rem sign both.
    assign w_a_sgn = bus.funct3[2] ? !bus.funct3[0] : (bus.funct3[0] ^ bus.funct3[1]);
    assign w_b_sgn = bus.funct3[2] ? !bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    assign w_a_neg = w_a_sgn && bus.src_a[XLEN-1];
    assign w_b_neg = w_b_sgn && bus.src_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_b_mag = w_b_neg ? -bus.src_b : bus.src_b;

    always_comb begin
        w_mul_add = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (r_mplier[j]) begin
                w_mul_add = w_mul_add + (r_mcand << j);
            end
        end
    end

    assign w_acc_nxt = r_acc + w_mul_add;
    assign w_prod    = r_mul_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_mul_res = r_mul_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

`ifdef ALU_EXEC_DIV_EN
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_want_rem;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_div_res;
    logic [XLEN-1:0] w_div0_res;

    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_dvs};
    assign w_ge       = !w_trial[XLEN];
    assign w_rem_nxt  = w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
    assign w_div_res  = r_want_rem ? (r_r_neg ? -w_rem_nxt : w_rem_nxt)
                                   : (r_q_neg ? -w_quo_nxt : w_quo_nxt);
    assign w_div0_res = bus.funct3[1] ? bus.src_a : {XLEN{1'b1}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_want_rem <= 1'b0;
        end else if (w_div_start) begin
            r_quo      <= w_a_mag;
            r_dvs      <= w_b_mag;
            r_rem      <= '0;
            r_q_neg    <= w_a_neg ^ w_b_neg;
            r_r_neg    <= w_a_neg;
            r_want_rem <= bus.funct3[1];
        end else if (r_state == S_DIV) begin
            r_quo      <= w_quo_nxt;
            r_rem      <= w_rem_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_load_ill  = 1'b0;
        w_mul_start = 1'b0;
        w_div_start = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if ((r_state == S_DONE) && bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                        w_mul_start = 1'b1;
                    end else if (w_is_div) begin
`ifdef ALU_EXEC_DIV_EN
                        if (bus.src_b == '0) begin
                            w_state_nxt = S_DONE;
                            w_load      = 1'b1;
                            w_load_val  = w_div0_res;
                        end else begin
                            w_state_nxt = S_DIV;
                            w_div_start = 1'b1;
                        end
`else
                        w_state_nxt = S_DONE;
                        w_load      = 1'b1;
                        w_load_ill  = 1'b1;
`endif
                    end else begin
                        w_state_nxt = S_DONE;
                        w_load      = 1'b1;
                        w_load_val  = w_base_res;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == c_ONE) begin
                    w_state_nxt = S_DONE;
                    w_load      = 1'b1;
                    w_load_val  = w_mul_res;
                end
            end
`ifdef ALU_EXEC_DIV_EN
            S_DIV: begin
                if (r_cnt == c_ONE) begin
                    w_state_nxt = S_DONE;
                    w_load      = 1'b1;
                    w_load_val  = w_div_res;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_mul_neg <= 1'b0;
            r_mul_hi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_result  <= w_load_val;
                r_zero    <= (w_load_val == '0);
                r_illegal <= w_load_ill;
            end
            if (w_mul_start) begin
                r_cnt <= c_MUL_CYCLES;
            end else if (w_div_start) begin
                r_cnt <= c_DIV_CYCLES;
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                r_cnt <= r_cnt - c_ONE;
            end
            // Magnitude product; the sign is applied once on the final sum.
            if (w_mul_start) begin
                r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                r_mplier  <= w_b_mag;
                r_acc     <= '0;
                r_mul_neg <= w_a_neg ^ w_b_neg;
                r_mul_hi  <= (bus.funct3[1:0] != 2'b00);
            end else if (r_state == S_MUL) begin
                r_acc     <= w_acc_nxt;
                r_mcand   <= r_mcand << MUL_STEP;
                r_mplier  <= r_mplier >> MUL_STEP;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_alu_exec_unit                                                |
// | Purpose : Vector table plus handshake/reset sequences for alu_exec_unit   |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_alu_exec_unit;

    localparam int XLEN     = 32;
    localparam int MUL_STEP = 1;

    typedef struct {
        logic [1:0]  alu_op;
        logic [2:0]  f3;
        logic        op5;
        logic        f75;
        logic        f70;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs[$];
    exp_t sbq[$];

    alu_exec_if #(.XLEN(XLEN)) bus ();

    alu_exec_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // kind: 0 base, 1 mul, 2 div full latency, 3 divide by zero
    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic op5,
                                input logic f75, input logic f70, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int kind);
        vec_t v;
        v.alu_op = op; v.f3 = f3; v.op5 = op5; v.f75 = f75; v.f70 = f70;
        v.a = a; v.b = b; v.exp = exp; v.ill = 1'b0;
        case (kind)
            1:       v.lat = 1 + XLEN / MUL_STEP;
            2:       v.lat = 1 + XLEN;
            default: v.lat = 1;
        endcase
`ifndef ALU_EXEC_DIV_EN
        if (kind >= 2) begin
            v.exp = 32'h0; v.ill = 1'b1; v.lat = 1;
        end
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", bus.result);
            end else begin
                e = sbq.pop_front();
                chk("result",  64'(bus.result),  64'(e.res));
                chk("illegal", 64'(bus.illegal), 64'(e.ill));
                chk("zero",    64'(bus.zero),    64'(e.res == 32'h0));
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.alu_op   = v.alu_op;
        bus.funct3   = v.f3;
        bus.op_5     = v.op5;
        bus.funct7_5 = v.f75;
        bus.funct7_0 = v.f70;
        bus.src_a    = v.a;
        bus.src_b    = v.b;
        bus.in_valid = 1'b1;
    endtask

    task automatic scramble();
        bus.in_valid = 1'b0;
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        bus.funct3   = 3'($urandom);
        bus.alu_op   = 2'($urandom);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int cyc;
        drive(v);
        sbq.push_back('{v.exp, v.ill});
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        scramble();
        wait_valid(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(v.lat));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic seen;
        vec_t v;
        checks = 0; failures = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.alu_op = 2'b00; bus.funct3 = 3'b000; bus.op_5 = 1'b0;
        bus.funct7_5 = 1'b0; bus.funct7_0 = 1'b0; bus.src_a = '0; bus.src_b = '0;

        vecs.push_back(mk(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       0));
        vecs.push_back(mk(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5,        32'd7,        32'hFFFFFFFE, 0));
        vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd5,        32'd7,        32'hFFFFFFFE, 0));
        vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd5,        32'd7,        32'd12,       0));
        vecs.push_back(mk(2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 32'd1,        32'hFFFFFFE1, 32'd2,        0));
        vecs.push_back(mk(2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        0));
        vecs.push_back(mk(2'b10, 3'b011, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        0));
        vecs.push_back(mk(2'b10, 3'b100, 1'b1, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0));
        vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 0));
        vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 0));
        vecs.push_back(mk(2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0));
        vecs.push_back(mk(2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0));
        vecs.push_back(mk(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1,        32'hDEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        0));
        vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 32'd5,        32'd7,        32'd12,       0));
        vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1));
        vecs.push_back(mk(2'b10, 3'b001, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1));
        vecs.push_back(mk(2'b10, 3'b011, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1));
        vecs.push_back(mk(2'b10, 3'b010, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1));
        vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h10,       32'h23456780, 1));
        vecs.push_back(mk(2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 2));
        vecs.push_back(mk(2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 2));
        vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'd7,        32'd0,        32'hFFFFFFFF, 3));
        vecs.push_back(mk(2'b10, 3'b111, 1'b1, 1'b0, 1'b1, 32'd7,        32'd0,        32'd7,        3));
        vecs.push_back(mk(2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2));
        vecs.push_back(mk(2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2));
        vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       2));
        vecs.push_back(mk(2'b10, 3'b111, 1'b1, 1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        2));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result",    64'(bus.result),    64'd0);
        chk("rst_zero",      64'(bus.zero),      64'd0);
        chk("rst_illegal",   64'(bus.illegal),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Consumer stall for five cycles, then drain and accept in one cycle.
        bus.out_ready = 1'b0;
        v = mk(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 0);
        drive(v);
        sbq.push_back('{v.exp, v.ill});
        @(posedge clk); #1;
        scramble();
        wait_valid(cyc);
        chk("stall_latency", 64'(cyc), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_result",   64'(bus.result),    64'd7);
            chk("stall_valid",    64'(bus.out_valid), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready),  64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        v = mk(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd4, 32'd5, 0);
        drive(v);
        sbq.push_back('{v.exp, v.ill});
        @(negedge clk);
        chk("overlap_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        scramble();
        @(negedge clk);
        chk("overlap_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;

        // Reset in the middle of a multiply must discard it.
        v = mk(2'b10, 3'b011, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        drive(v);
        @(posedge clk); #1;
        scramble();
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midrst_no_stale", 64'(seen), 64'd0);
        @(posedge clk); #1;
        do_op(mk(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd40, 32'd2, 32'd42, 0), "post_rst");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
